// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce_edge input-conditioning block:
// FSM state encoding and elaboration-time parameter legality checks.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } db_state_e;

  // The counter must be able to hold STABLE_CYCLES-1 without wrapping.
  function automatic bit params_legal(input int sync_stages,
                                      input int stable_cycles,
                                      input int cnt_w);
    longint cap;
    if (sync_stages < 2 || stable_cycles < 2) return 1'b0;
    if (cnt_w < 1 || cnt_w > 62) return 1'b0;
    cap = longint'(1) << cnt_w;
    return cap >= longint'(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// N-stage synchroniser for an asynchronous single-bit input; every stage
// clears to 0 on synchronous reset.
module sync_chain #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] stage_d;
  logic [N-1:0] stage_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_d[gi] = d_i;
    end else begin : g_rest
      assign stage_d[gi] = stage_q[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/debounce_edge.sv
// Debouncer: synchronises din, qualifies a new level over STABLE_CYCLES
// tick samples and emits registered level plus one-cycle rise/fall strobes.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  if (!params_legal(SYNC_STAGES, STABLE_CYCLES, CNT_W)) begin : g_param_err
    $error("debounce_edge: illegal SYNC_STAGES/STABLE_CYCLES/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic      s;
  db_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic      level_q;
  logic      rise_q;
  logic      fall_q;

  sync_chain #(
    .N (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (din),
    .q_o (s)
  );

  // Glitch rejection is evaluated every cycle; only counting waits on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_q <= WAIT_HI;
            cnt_q   <= CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= IDLE_HI;
              cnt_q   <= '0;
              level_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_q <= WAIT_LO;
            cnt_q   <= CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_q <= IDLE_HI;
            cnt_q   <= '0;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= IDLE_LO;
              cnt_q   <= '0;
              level_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= IDLE_LO;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign busy  = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: spec-timing vector table, directed
// corner sequences, then random din/tick/rst against a behavioural model.
module tb_debounce_edge;

  localparam int SYNC   = 2;
  localparam int STABLE = 16;

  logic clk = 1'b0;
  logic rst, din, tick;
  logic level, rise, fall, busy;

  always #5 clk = ~clk;

  debounce_edge #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .tick  (tick),
    .level (level),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  typedef struct {
    logic din;
    logic tick;
    logic level;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: din history delayed by SYNC edges gives the synchronised
  // sample; a candidate level is accepted once it has persisted unbroken and
  // collected STABLE-1 tick samples after it was first seen.
  logic hist[SYNC];
  logic m_level, m_rise, m_fall, m_pend;
  int   m_ticks;

  task automatic model_edge(input logic r, input logic d, input logic t);
    logic s;
    if (r) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      m_level = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_ticks = 0;
      return;
    end
    s = hist[SYNC-1];
    m_rise = 0;
    m_fall = 0;
    if (!m_pend) begin
      if (s != m_level) begin
        m_pend  = 1;
        m_ticks = 0;
      end
    end else if (s == m_level) begin
      m_pend = 0;
    end else if (t) begin
      m_ticks++;
      if (m_ticks == STABLE - 1) begin
        m_level = ~m_level;
        m_rise  = m_level;
        m_fall  = ~m_level;
        m_pend  = 0;
      end
    end
    for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
  endtask

  task automatic step(input logic r, input logic d, input logic t);
    rst = r; din = d; tick = t;
    @(posedge clk);
    model_edge(r, d, t);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic l, input logic r,
                         input logic f, input logic b);
    chk({nm, ".level"}, level, l);
    chk({nm, ".rise"},  rise,  r);
    chk({nm, ".fall"},  fall,  f);
    chk({nm, ".busy"},  busy,  b);
  endtask

  vec_t tbl[24];

  initial begin
    logic seen_busy, seen_rise;
    int   run_left;
    logic rd, rt, rr;

    rst = 1; din = 0; tick = 1;
    for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
    m_level = 0; m_rise = 0; m_fall = 0; m_pend = 0; m_ticks = 0;

    // Clean-rise table: vector k is applied before edge k+1 after reset release.
    for (int k = 0; k < 24; k++) begin
      int e;
      e = k + 1;
      tbl[k].din   = 1'b1;
      tbl[k].tick  = 1'b1;
      tbl[k].level = (e >= SYNC + STABLE);
      tbl[k].rise  = (e == SYNC + STABLE);
      tbl[k].fall  = 1'b0;
      tbl[k].busy  = (e >= SYNC + 1) && (e < SYNC + STABLE);
    end

    @(negedge clk);

    // 1. Reset held with din=1
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 1);
      chk_all("reset", 0, 0, 0, 0);
    end

    // 2. Clean rise from table
    step(1, 0, 1);
    for (int k = 0; k < 24; k++) begin
      step(0, tbl[k].din, tbl[k].tick);
      chk_all($sformatf("rise_tbl[%0d]", k), tbl[k].level, tbl[k].rise,
              tbl[k].fall, tbl[k].busy);
    end

    // 4. Fall from level=1
    for (int k = 1; k <= 22; k++) begin
      step(0, 0, 1);
      chk_all($sformatf("fall[%0d]", k), (k < SYNC + STABLE) ? 1'b1 : 1'b0, 0,
              (k == SYNC + STABLE), (k >= SYNC + 1) && (k < SYNC + STABLE));
    end

    // 3. Five-cycle glitch is rejected
    seen_busy = 0; seen_rise = 0;
    for (int k = 1; k <= 15; k++) begin
      step(0, (k <= 5), 1);
      seen_busy |= busy;
      seen_rise |= rise;
      chk($sformatf("glitch_busy[%0d]", k), busy, (k >= 3) && (k <= 7));
    end
    chk("glitch_saw_busy", seen_busy, 1'b1);
    chk("glitch_no_rise", seen_rise, 1'b0);
    chk("glitch_level", level, 1'b0);

    // 5. Tick gating: hold WAIT_HI, then count 15 tick edges
    step(1, 0, 0);
    for (int k = 1; k <= 30; k++) begin
      step(0, 1, 0);
      chk($sformatf("gate_busy[%0d]", k), busy, (k >= SYNC + 1));
      chk($sformatf("gate_rise[%0d]", k), rise, 1'b0);
    end
    for (int j = 1; j <= 17; j++) begin
      step(0, 1, 1);
      chk($sformatf("gate_tick_rise[%0d]", j), rise, (j == STABLE - 1));
      chk($sformatf("gate_tick_level[%0d]", j), level, (j >= STABLE - 1));
    end

    // 6. Reset mid-wait (counter at 10), then requalify with din still 1
    step(1, 0, 1);
    for (int k = 1; k <= 12; k++) step(0, 1, 1);
    chk("midwait_busy_before", busy, 1'b1);
    step(1, 1, 1);
    chk_all("midwait_reset", 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 1);
      chk_all($sformatf("midwait_req[%0d]", k), (k >= SYNC + STABLE),
              (k == SYNC + STABLE), 0, (k >= SYNC + 1) && (k < SYNC + STABLE));
    end

    // Randomised runs against the reference model
    rd = 0; run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        rd = $urandom_range(1, 0);
        run_left = ($urandom_range(3, 0) == 0) ? $urandom_range(6, 1)
                                               : $urandom_range(40, 8);
      end
      run_left--;
      rt = ($urandom_range(3, 0) != 0);
      rr = ($urandom_range(499, 0) == 0);
      step(rr, rd, rt);
      chk_all($sformatf("rand[%0d]", c), m_level, m_rise, m_fall, m_pend);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Input-conditioning stage that sits directly upstream of the flip-flop cells (dff, dffe, dffer, dffesr). It turns an asynchronous, possibly bouncing input into a clean synchronous level plus single-cycle rise and fall strobes. Those outputs drive the `d`, `en` and `rst` pins of the downstream registers.

## Interface
- `SYNC_STAGES`, default 2: depth of the synchroniser chain; must be ≥ 2.
- `STABLE_CYCLES`, default 16: number of consecutive qualifying samples needed to accept a new level; must be ≥ 2.
- `CNT_W`, default 8: stability counter width; elaboration error unless 2^CNT_W ≥ STABLE_CYCLES.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  asynchronous raw input.
- `tick` in  1  sample enable; the counter advances only when `tick`=1. Tie high for per-cycle operation.
- `level` out 1  debounced level.
- `rise` out 1  one-cycle pulse when `level` goes 0→1.
- `fall` out 1  one-cycle pulse when `level` goes 1→0.
- `busy` out 1  high while a candidate transition is being qualified.

## Operation
- Synchroniser: `din` passes through `SYNC_STAGES` flops. The last flop is the synchronised value `s`.
- The FSM has four states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
- IDLE_LO:
  - `s`=1 → WAIT_HI with cnt=1. This entry does not depend on `tick`.
  - Otherwise stay in IDLE_LO.
- WAIT_HI, evaluated every cycle:
  - `s`=0 → IDLE_LO, cnt=0 (glitch rejected, no strobe).
  - Else if `tick`=1 and cnt=STABLE_CYCLES−1 → IDLE_HI, `level`←1, `rise`←1.
  - Else if `tick`=1 → cnt+1.
  - Else hold.
- IDLE_HI and WAIT_LO mirror the above with `s` inverted. Acceptance sets `level`←0 and `fall`←1.
- `busy` = state ∈ {WAIT_HI, WAIT_LO}.
- `rise` and `fall` are registered, high for exactly one cycle, and never high together.
- cnt is unsigned CNT_W bits. It never exceeds STABLE_CYCLES−1, so it never wraps.
- Glitch checking runs every cycle regardless of `tick`. A single-cycle wrong `s` value restarts qualification from IDLE.
- Reset, at any time including mid-WAIT:
  - All synchroniser flops 0, state IDLE_LO, cnt 0.
  - `level`=0, `rise`=0, `fall`=0, `busy`=0.
  - A pending transition is discarded with no strobe.
- If `din` is 1 when reset releases, the block requalifies from IDLE_LO and then issues `rise`.

## Timing
- Latency with `tick`=1 and `din` 0→1 set up before edge 1:
  - `s`=1 after edge SYNC_STAGES.
  - WAIT_HI entered at edge SYNC_STAGES+1.
  - `level`=1 and `rise`=1 after edge SYNC_STAGES+STABLE_CYCLES (edge 18 with default parameters).
  - `rise` drops after the next edge.
- Fall latency is identical.
- Minimum accepted pulse width is STABLE_CYCLES samples. Anything shorter produces no output change.
- With `tick` gated, each WAIT state needs STABLE_CYCLES−1 tick-qualified edges after entry.
- Outputs are registered, with no combinational path from `din` or `tick` to any output.

## Structure
- Shared package `debounce_pkg` holds:
  - The state enum (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO) with an explicit 2-bit encoding.
  - The parameter legality checks.
- Sub-module `sync_chain`: parameterised N-stage synchroniser with synchronous active-high reset, built from the same reset-flop style as `dffer`.
- The top level instantiates `sync_chain` and contains the FSM, counter and output registers.

## Test plan
All scenarios use default parameters.
1. **Reset:** `rst`=1 for 3 cycles with `din`=1 → `level`=0, `rise`=0, `fall`=0, `busy`=0 throughout.
2. **Clean rise:** `din` 0→1 before edge 1, `tick`=1 → `busy`=1 after edge 3; `level`=1 and `rise`=1 after edge 18; `rise`=0 after edge 19; `level` stays 1.
3. **Glitch:** `din` high for 5 cycles then low → `busy` pulses and returns to 0; no `rise`; `level` stays 0.
4. **Fall:** from `level`=1, `din` 1→0 → `fall` pulse after edge 18 relative to the change; `level`=0; `rise` stays 0.
5. **Tick gating:** `din`=1, `tick`=0 → FSM holds WAIT_HI with cnt=1 and `busy`=1 indefinitely. Then set `tick`=1 → `rise` after the 15th tick edge.
6. **Reset mid-wait:** assert `rst` when cnt=10 during a rise qualification → no `rise`, `busy`=0. After release with `din` still 1 → `rise` after edge 18 counted from release.
